// File: rtl/gpio_irq.sv
// gpio_irq: 16-pin GPIO edge interrupt controller with a byte-wide CPU bus.
// Per-pin logic: synchronizer, edge detector and pending flag.
// Registers: PEND (W1C), EN, POL and LVL (read-only).
// Build option GPIO_IRQ_SYNC2_EN: when defined, a 2-flop pin synchronizer is
// used. Otherwise a single flop is used and PEND sets one cycle earlier.
module gpio_irq #(
    parameter int NUM_LANES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] AD,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    input  logic       rw,
    input  logic       cs,
    input  logic [NUM_LANES-1:0] pins,
    output logic       irq
);

    typedef struct packed {
        logic       wr;
        logic [1:0] sel;   // 0 PEND, 1 EN, 2 POL, 3 LVL
        logic       lo;    // odd address -> bits 7:0
        logic [7:0] data;
    } bus_req_t;

    bus_req_t             req;
    logic [NUM_LANES-1:0] en;
    logic [NUM_LANES-1:0] pol;
    logic [NUM_LANES-1:0] pend;
    logic [NUM_LANES-1:0] lvl;
    logic [NUM_LANES-1:0] clr;
    logic [15:0]          rd_word;

    assign req.wr   = cs & ~rw;
    assign req.sel  = AD[2:1];
    assign req.lo   = AD[0];
    assign req.data = DI;

    // Write-1-to-clear mask for PEND, aligned to the addressed byte
    always_comb begin
        clr = '0;
        if (req.wr && req.sel == 2'd0) begin
            if (req.lo) clr[7:0]  = req.data;
            else        clr[15:8] = req.data;
        end
    end

    // Per-lane synchronizer, history, edge detect and sticky pending flag
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic prev;
        logic det;
`ifdef GPIO_IRQ_SYNC2_EN
        logic sync1;
        // Two-flop synchronizer followed by the history flop
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1  <= 1'b0;
                lvl[i] <= 1'b0;
                prev   <= 1'b0;
            end else begin
                sync1  <= pins[i];
                lvl[i] <= sync1;
                prev   <= lvl[i];
            end
        end
`else
        // Single-flop synchronizer followed by the history flop
        always_ff @(posedge clk) begin
            if (rst) begin
                lvl[i] <= 1'b0;
                prev   <= 1'b0;
            end else begin
                lvl[i] <= pins[i];
                prev   <= lvl[i];
            end
        end
`endif
        // Only a real change of the synced level counts, so flipping POL never
        // fakes an edge.
        assign det = pol[i] ? (lvl[i] & ~prev) : (~lvl[i] & prev);

        // Set wins over a same-cycle clear; disabled edges are simply dropped
        always_ff @(posedge clk) begin
            if (rst) pend[i] <= 1'b0;
            else     pend[i] <= (pend[i] & ~clr[i]) | (det & en[i]);
        end
    end

    // EN / POL byte writes; reset overrides any concurrent bus write
    always_ff @(posedge clk) begin
        if (rst) begin
            en  <= '0;
            pol <= '0;
        end else if (req.wr) begin
            case (req.sel)
                2'd1: if (req.lo) en[7:0]  <= req.data; else en[15:8]  <= req.data;
                2'd2: if (req.lo) pol[7:0] <= req.data; else pol[15:8] <= req.data;
                default: ;
            endcase
        end
    end

    // Side-effect-free read mux
    always_comb begin
        case (req.sel)
            2'd0:    rd_word = pend;
            2'd1:    rd_word = en;
            2'd2:    rd_word = pol;
            default: rd_word = lvl;
        endcase
        DO = req.lo ? rd_word[7:0] : rd_word[15:8];
    end

    // Interrupt is a pure function of flops, so pin glitches cannot reach it
    assign irq = |(pend & en);

endmodule
